// File: rtl/parity_pkg.sv
// Shared definitions for the parity framing block: FSM state encoding,
// coded-word geometry and a helper that packs a nibble with its parity bit.
package parity_pkg;

    localparam int NIB_W  = 4;
    localparam int WORD_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Coded word layout: nibble in the upper bits, parity in bit 0.
    function automatic logic [WORD_W-1:0] make_word(input logic [NIB_W-1:0] nib,
                                                    input logic             par);
        return {nib, par};
    endfunction

endpackage

// File: rtl/parity4.sv
// Four-input XOR used to compute the even parity of one data nibble.
module parity4 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic e
);

    assign e = a ^ b ^ c ^ d;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Frames FRAME_LEN nibbles into 5-bit parity-coded words through a one-deep
// output register, then reports the XOR of all word parities of the frame.
module parity_frame_ctrl
    import parity_pkg::*;
#(
    parameter int FRAME_LEN = 4,
    parameter int ODD       = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [NIB_W-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_parity
);

    localparam logic [3:0] LEN_C = 4'(FRAME_LEN);
    localparam logic       ODD_C = 1'(ODD);

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic [3:0]          cnt_d;
    logic                acc_q;
    logic                out_valid_q;
    logic [WORD_W-1:0]   out_data_q;
    logic                frame_done_q;
    logic                frame_parity_q;

    logic                nib_par;
    logic                word_par;
    logic                accept;
    logic                pop;

    parity4 u_parity4 (
        .a (in_data[3]),
        .b (in_data[2]),
        .c (in_data[1]),
        .d (in_data[0]),
        .e (nib_par)
    );

    assign word_par = nib_par ^ ODD_C;
    assign cnt_d    = cnt_q + 4'd1;

    // Input is only taken in RUN and only when the output slot is free or draining now.
    assign in_ready = (state_q == RUN) & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign pop      = out_valid_q & out_ready;

    // Output register: load on accept (even while popping), clear on a bare pop, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= make_word(in_data, word_par);
        end else if (pop) begin
            out_valid_q <= 1'b0;
        end
    end

    // Frame sequencer: counts accepts, accumulates parity, waits for the output to drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            acc_q          <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_parity_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= 4'd0;
                        acc_q   <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        cnt_q <= cnt_d;
                        acc_q <= acc_q ^ word_par;
                        if (cnt_d == LEN_C) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Leave once the last word is gone (popped now or already absent).
                    if (!out_valid_q || pop) begin
                        state_q        <= DONE;
                        frame_done_q   <= 1'b1;
                        frame_parity_q <= acc_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign busy         = (state_q != IDLE);
    assign frame_done   = frame_done_q;
    assign frame_parity = frame_parity_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Self-checking bench: three configurations share one stimulus bus; the
// instance under test is chosen by sel and checked against a transaction model.
module tb_parity_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;

    logic [2:0] rdy_v, ov_v, busy_v, done_v, fp_v;
    logic [4:0] od_v [3];

    logic       o_ready, o_ov, o_busy, o_done, o_fp;
    logic [4:0] o_od;
    int         sel;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic       m_fp;
    logic [3:0] dir_nib [16];

    always #5 clk = ~clk;

    parity_frame_ctrl #(.FRAME_LEN(4), .ODD(0)) u4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_v[0]), .out_valid(ov_v[0]), .out_data(od_v[0]), .out_ready(out_ready),
        .busy(busy_v[0]), .frame_done(done_v[0]), .frame_parity(fp_v[0]));

    parity_frame_ctrl #(.FRAME_LEN(1), .ODD(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_v[1]), .out_valid(ov_v[1]), .out_data(od_v[1]), .out_ready(out_ready),
        .busy(busy_v[1]), .frame_done(done_v[1]), .frame_parity(fp_v[1]));

    parity_frame_ctrl #(.FRAME_LEN(15), .ODD(0)) u15 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_v[2]), .out_valid(ov_v[2]), .out_data(od_v[2]), .out_ready(out_ready),
        .busy(busy_v[2]), .frame_done(done_v[2]), .frame_parity(fp_v[2]));

    always_comb begin
        o_ready = rdy_v[sel];
        o_ov    = ov_v[sel];
        o_od    = od_v[sel];
        o_busy  = busy_v[sel];
        o_done  = done_v[sel];
        o_fp    = fp_v[sel];
    end

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s (inst %0d): observed=%0h expected=%0h", tag, sel, obs, exp);
        end
    endtask

    // Reference coding: nibble followed by (number of ones + odd) mod 2.
    function automatic logic [4:0] code(input logic [3:0] n, input bit odd);
        int ones;
        ones = $countones(n) + (odd ? 1 : 0);
        return {n, 1'(ones % 2)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
        m_fp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ready_mode: 0 = always ready, 1 = random, 2 = stalled 3 cycles after first accept
    task automatic run_frame(input int len, input bit odd, input bit use_dir, input int ready_mode);
        logic [3:0] nib [$];
        int         ones, acc_n, pop_n, cyc, hold_left;
        bit         m_ov, fin, do_acc, do_pop, last_pop, exp_rdy, in_run;
        logic [4:0] m_word;
        logic       exp_fp;

        ones = 0;
        for (int i = 0; i < len; i++) begin
            nib.push_back(use_dir ? dir_nib[i] : 4'($urandom_range(0, 15)));
            ones += $countones(nib[i]);
        end
        exp_fp = 1'((ones + (odd ? len : 0)) % 2);

        // Valid data offered while idle must be ignored.
        for (int k = 0; k < 2; k++) begin
            start = 1'b0; in_valid = 1'b1; in_data = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_in_ready", o_ready, 0);
            tick();
            chk("idle_out_valid", o_ov, 0);
            chk("idle_busy", o_busy, 0);
        end

        start = 1'b1; in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("start_in_ready", o_ready, 0);
        tick();
        start = 1'b0;
        chk("start_busy", o_busy, 1);

        m_ov = 0; m_word = '0; acc_n = 0; pop_n = 0; fin = 0; cyc = 0; hold_left = -1;
        while (!fin && cyc < 400) begin
            cyc++;
            in_run   = (acc_n < len);
            in_valid = in_run ? ((ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0))
                              : 1'($urandom_range(0, 1));
            in_data  = in_run ? nib[acc_n] : 4'($urandom_range(0, 15));
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 3) != 0);
                default: out_ready = (hold_left > 0) ? 1'b0 : 1'b1;
            endcase
            start = (ready_mode != 0) ? 1'($urandom_range(0, 5) == 0) : 1'b0;

            @(negedge clk);
            exp_rdy = in_run & (!m_ov | out_ready);
            chk("in_ready", o_ready, exp_rdy);
            do_acc   = in_valid & exp_rdy;
            do_pop   = m_ov & out_ready;
            last_pop = 0;
            if (do_pop) begin
                chk("pop_word", o_od, code(nib[pop_n], odd));
                pop_n++;
                last_pop = (pop_n == len);
            end
            if (do_acc) begin
                m_word = code(nib[acc_n], odd);
                m_ov   = 1;
                acc_n++;
            end else if (do_pop) begin
                m_ov = 0;
            end
            if (ready_mode == 2) begin
                if (hold_left > 0) hold_left--;
                else if (hold_left < 0 && do_acc) hold_left = 3;
            end

            tick();
            chk("out_valid", o_ov, m_ov);
            if (m_ov) chk("out_data", o_od, m_word);
            chk("busy", o_busy, 1);
            if (last_pop) begin
                chk("frame_done", o_done, 1);
                chk("frame_parity", o_fp, exp_fp);
                m_fp = exp_fp;
                fin  = 1;
            end else begin
                chk("no_frame_done", o_done, 0);
                chk("parity_held", o_fp, m_fp);
            end
        end
        chk("frame_timeout", 5'(fin), 1);
        chk("words_delivered", 5'(pop_n), 5'(len));

        start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("done_in_ready", o_ready, 0);
        tick();
        chk("done_pulse_end", o_done, 0);
        chk("done_busy", o_busy, 0);
        chk("parity_after", o_fp, m_fp);
        $display("frame inst=%0d len=%0d odd=%0d mode=%0d words=%0d parity=%0d",
                 sel, len, odd, ready_mode, pop_n, m_fp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
        m_fp = 1'b0;
        #3;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_out_valid", o_ov, 0);
            chk("rst_out_data", o_od, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_in_ready", o_ready, 0);
            chk("rst_frame_done", o_done, 0);
            chk("rst_frame_parity", o_fp, 0);
        end
        sel = 0;
        do_reset();

        // Directed frame 1,3,7,F, always ready.
        dir_nib[0] = 4'h1; dir_nib[1] = 4'h3; dir_nib[2] = 4'h7; dir_nib[3] = 4'hF;
        run_frame(4, 0, 1, 0);
        chk("directed_word0", code(dir_nib[0], 0), 5'h03);
        chk("directed_word3", code(dir_nib[3], 0), 5'h1E);

        // Output stalled for 3 cycles after first accept.
        run_frame(4, 0, 0, 2);
        run_frame(4, 0, 0, 1);

        // Odd parity, single-nibble frame.
        sel = 1;
        do_reset();
        dir_nib[0] = 4'h0;
        run_frame(1, 1, 1, 0);
        chk("odd_parity_final", o_fp, 1);
        run_frame(1, 1, 0, 1);

        // Two back-to-back 15-nibble frames.
        sel = 2;
        do_reset();
        run_frame(15, 0, 0, 1);
        run_frame(15, 0, 0, 1);

        // Reset in the middle of a frame after two accepts.
        sel = 0;
        do_reset();
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 4'h5;
        tick();
        in_data = 4'h6;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_busy", o_busy, 1);
        chk("pre_rst_out_valid", o_ov, 1);
        chk("pre_rst_out_data", o_od, code(4'h6, 0));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", o_ov, 0);
        chk("async_rst_out_data", o_od, 0);
        chk("async_rst_busy", o_busy, 0);
        chk("async_rst_in_ready", o_ready, 0);
        chk("async_rst_frame_done", o_done, 0);
        m_fp = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_no_done", o_done, 0);
        end
        run_frame(4, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
